// File: rtl/adam_tag_mem_ctrl_pkg.sv
// Shared types for the tag memory front-end: response record and controller state.
// tag_t is sized for the widest supported tag; narrower tags are zero-extended.
package adam_tag_mem_ctrl_pkg;

  localparam int MAX_TAG_WIDTH = 8;

  typedef logic [MAX_TAG_WIDTH-1:0] tag_t;

  typedef struct packed {
    tag_t tag;
    logic err;
  } tag_rsp_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } tag_ctrl_state_e;

endpackage

// File: rtl/adam_tag_mem_ctrl_if.sv
// Request/response/clear/memory-port bundle between the DIFT logic, the controller
// and adam_tag_mem. slave = controller view, master = environment view.
interface adam_tag_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_we;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [TAG_WIDTH-1:0]  rsp_tag;
  logic                  rsp_err;
  logic                  clr_start;
  logic                  clr_busy;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [STRB_WIDTH-1:0] mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_we, req_tag, rsp_ready, clr_start, mem_rdata,
    output req_ready, rsp_valid, rsp_tag, rsp_err, clr_busy,
           mem_req, mem_addr, mem_we, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_addr, req_we, req_tag, rsp_ready, clr_start, mem_rdata,
    input  req_ready, rsp_valid, rsp_tag, rsp_err, clr_busy,
           mem_req, mem_addr, mem_we, mem_be, mem_wdata
  );

endinterface

// File: rtl/adam_tag_rsp_fifo.sv
// Two-entry read-response FIFO. Upstream credit logic guarantees no push into a full
// FIFO unless the head is popped in the same cycle.
module adam_tag_rsp_fifo
  import adam_tag_mem_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push_valid,
  input  tag_rsp_t push_data,
  output logic     pop_valid,
  input  logic     pop_ready,
  output tag_rsp_t pop_data,
  output logic [1:0] count
);

  tag_rsp_t   mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign pop_valid = (count_q != 2'd0);
  assign pop_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign do_pop    = pop_valid & pop_ready;
  assign do_push   = push_valid & ((count_q != 2'd2) | do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: payload storage has no reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/adam_tag_mem_ctrl.sv
// Front-end for adam_tag_mem: maps tag requests onto the raw memory port, returns read
// tags through a 2-entry FIFO, and runs a one-word-per-cycle clear sweep.
module adam_tag_mem_ctrl
  import adam_tag_mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SIZE           = 4096,
  parameter int TAG_WIDTH      = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic                clk,
  input logic                rst,
  adam_tag_mem_ctrl_if.slave bus
);

  localparam int STRB_WIDTH   = DATA_WIDTH / 8;
  localparam int WORD_LSB     = $clog2(STRB_WIDTH);
  localparam int ALIGNED_SIZE = SIZE / STRB_WIDTH;
  localparam int IDX_WIDTH    = $clog2(ALIGNED_SIZE);

  tag_ctrl_state_e      state_q, state_d;
  logic [IDX_WIDTH-1:0] idx_q;
  logic                 inflight_q;
  logic                 inflight_err_q;
  logic                 in_range;
  logic                 accept;
  logic                 rd_accept;
  logic                 pop;
  logic                 fifo_valid;
  logic [1:0]           fifo_count;
  logic [2:0]           occupancy;
  tag_rsp_t             push_data;
  tag_rsp_t             head;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= CLEAR_ON_RESET ? CLEAR : IDLE;
      idx_q          <= '0;
      inflight_q     <= 1'b0;
      inflight_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      inflight_q     <= rd_accept;
      inflight_err_q <= rd_accept & ~in_range;
      idx_q          <= (state_q == CLEAR) ? idx_q + IDX_WIDTH'(1) : '0;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.clr_start) state_d = CLEAR;
      CLEAR:   if (idx_q == IDX_WIDTH'(ALIGNED_SIZE - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slots already promised = queued + in flight, minus the head leaving this cycle.
  assign in_range  = bus.req_addr < ADDR_WIDTH'(SIZE);
  assign pop       = fifo_valid & bus.rsp_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign accept    = bus.req_valid & bus.req_ready;
  assign rd_accept = accept & ~bus.req_we;

  always_comb begin
    bus.req_ready = ~rst & (state_q == IDLE) & ~bus.clr_start
                  & (bus.req_we | (occupancy < 3'd2));
    bus.clr_busy  = ~rst & (state_q == CLEAR);
    bus.rsp_valid = ~rst & fifo_valid;
    bus.rsp_tag   = bus.rsp_valid ? head.tag[TAG_WIDTH-1:0] : '0;
    bus.rsp_err   = bus.rsp_valid & head.err;
  end

  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    if (rst) begin
      bus.mem_req = 1'b0;
    end else if (state_q == CLEAR) begin
      bus.mem_req  = 1'b1;
      bus.mem_we   = 1'b1;
      bus.mem_be   = STRB_WIDTH'(1);
      bus.mem_addr = ADDR_WIDTH'(idx_q) << WORD_LSB;
    end else if (accept && in_range) begin
      bus.mem_req  = 1'b1;
      bus.mem_we   = bus.req_we;
      bus.mem_be   = bus.req_we ? STRB_WIDTH'(1) : '0;
      bus.mem_addr = bus.req_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
      if (bus.req_we) bus.mem_wdata = DATA_WIDTH'(bus.req_tag);
    end
  end

  // Out-of-range reads still occupy a response slot so ordering is preserved.
  always_comb begin
    push_data.err = inflight_err_q;
    push_data.tag = inflight_err_q ? '0 : tag_t'(bus.mem_rdata[TAG_WIDTH-1:0]);
  end

  adam_tag_rsp_fifo u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_valid(inflight_q),
    .push_data (push_data),
    .pop_valid (fifo_valid),
    .pop_ready (bus.rsp_ready),
    .pop_data  (head),
    .count     (fifo_count)
  );

endmodule
